uart_tx_param: RTL and testbench
================================

Name: uart_tx_param

Overview:
- Parametrised UART transmitter; successor to the fixed 8N1 baud-clocked transmitter.
- Runs on the system clock with an internal baud-tick divider, so no separate baud clock is needed.
- Configurable data width, parity mode and stop bits; valid/ready byte handshake.
- Sits between the sensor/control logic and the board TX pin.

Parameters:
- CLKS_PER_BIT, 434, system clocks per bit (50 MHz / 115200); legal range is 2 or more.
- DATA_BITS, 8, payload bits per frame; legal range 5..9.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, number of stop bits; 1 or 2.
- FIFO_DEPTH, 4, depth of the input FIFO; only used when UARTTX_FIFO_EN is defined; power of 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- tx_valid  in  1  tx_data is presented for sending.
- tx_data  in  DATA_BITS  payload; sent LSB first.
- tx_ready  out  1  block can accept a word this cycle.
- tx  out  1  serial line; idles high.
- busy  out  1  a frame is in progress (state is not IDLE).

Behaviour:
- Reset values: tx=1, busy=0, tx_ready=0 during rst, state=IDLE, baud counter=0, bit index=0.
- rst is sampled on the clk edge. On reset mid-frame: tx=1 from the next cycle, the in-flight word is discarded, there is no stop-bit completion, and (with the FIFO) the FIFO is emptied.
- Handshake: a word is accepted on a clk edge where tx_valid && tx_ready. tx_data is captured into a shift register at that edge. The source may change tx_data afterwards.
- Without the FIFO, tx_ready=1 when:
  - state=IDLE and not in reset, or
  - in the final clk cycle of the last stop bit (allows back-to-back frames).
- State machine, one state per field:
  - IDLE -> START on accept. tx goes low on the first cycle after the accept edge (latency 1 clk).
  - START: tx=0 for CLKS_PER_BIT cycles, then -> DATA.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit. Shift right and bump the bit index on each bit end. After DATA_BITS bits -> PARITY if PARITY!=0, else -> STOP.
  - PARITY: tx = XOR of the payload (even mode) or its inverse (odd mode) for CLKS_PER_BIT cycles -> STOP. Parity is computed from the captured word, not from live tx_data.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. At the end: -> START if a word was accepted in the last cycle, else -> IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1. It clears on accept, so the start bit is exactly CLKS_PER_BIT cycles. It wraps to 0 at each bit boundary. Width is $clog2(CLKS_PER_BIT).
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles. Back-to-back frames have no idle gap.
- tx_valid asserted during DATA/PARITY (no FIFO): tx_ready=0, so the word is held by the source and not dropped.
- X on tx_data while tx_valid=0 has no effect.

Optional Feature:
- Macro: UARTTX_FIFO_EN.
- Defined:
  - A FIFO_DEPTH-entry input FIFO is placed in front of the frame engine, with tx_ready = !full.
  - The engine pops the FIFO when IDLE and non-empty, or at the end of a stop bit.
  - A push when full is impossible (tx_ready=0).
  - Simultaneous push and pop when full is allowed: tx_ready=0, so only the pop happens.
  - Simultaneous push and pop when empty: the pushed word is not popped the same cycle; it starts on the next cycle.
  - busy=1 while FIFO non-empty or state!=IDLE.
  - Latency from push into an idle, empty engine: tx low 2 cycles after the accept edge.
- Not defined: the behaviour is exactly as above, with no storage beyond the shift register.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - parity-mode constants PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2;
  - default CLKS_PER_BIT_115200 = 434.
- Sub-module uart_baud_gen (counter with sync clear, tick output). Reusable by a future parametrised receiver.
- The FIFO is inline under the macro; no separate module.

Test Plan:
- CLKS_PER_BIT=4, 8N1; push 0x55 -> tx=0 for 4 clk, then 1,0,1,0,1,0,1,0 at 4 clk each, then 1 for 4 clk; 40-clk frame; tx_ready returns high on the last stop cycle.
- PARITY=2 (even); push 0x07 -> parity bit=1. PARITY=1 (odd) with 0x07 -> parity bit=0. Frame is 44 clk.
- tx_valid held high with 0xA3 then 0x5C -> second start bit immediately follows the first stop bit with no idle cycle; two frames in 80 clk.
- DATA_BITS=7, STOP_BITS=2; push 0x7F -> 1+7+2 bits = 40 clk; tx high for 8 clk at the end; the bit-8 payload is ignored.
- Assert rst at clk 13 of a 0xFF frame -> tx=1 and busy=0 on the next cycle. A new push after reset sends a full, correct frame.
- UARTTX_FIFO_EN, FIFO_DEPTH=4; push 5 words with tx_valid constant -> tx_ready drops after the 5th accept (1 in engine + 4 queued). All 5 words are emitted in order: 0x01,0x02,0x03,0x04,0x05.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-engine states, parity modes and the default baud divider.
// Used by the transmitter now and intended for a future parametrised receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // 50 MHz system clock / 115200 baud
    localparam int CLKS_PER_BIT_115200 = 434;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 while enabled and pulses tick_o on the last count.
// A synchronous clear restarts the period so a new bit is exactly CLKS_PER_BIT cycles long.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || !en_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_BITS payload LSB first, optional parity, 1-2 stop bits.
// Define UARTTX_FIFO_EN to place a FIFO_DEPTH-entry input FIFO in front of the frame engine.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = PAR_NONE,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
        (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
        $error("uart_tx_param: illegal parameter value");
    end

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, load_data;
    logic                 par_q, par_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 tick, load, stop_end;

    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return (PARITY == PAR_ODD) ? ~(^d) : ^d;
    endfunction

    uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk_i  (clk),
        .rst_i  (rst),
        .clr_i  (load),
        .en_i   (state_q != ST_IDLE),
        .tick_o (tick)
    );

    // idx_q doubles as the stop-bit counter once the payload is out
    assign stop_end = (state_q == ST_STOP) && tick && (idx_q == LAST_STOP);

`ifdef UARTTX_FIFO_EN
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_q, rd_q;
    logic [PTR_W:0]       cnt_q;
    logic                 push, pop, empty, full;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == (PTR_W + 1)'(FIFO_DEPTH));
    assign tx_ready = !rst && !full;
    assign push     = tx_valid && tx_ready;
    // empty is registered, so a word pushed into an empty FIFO starts one cycle later
    assign pop      = !empty && ((state_q == ST_IDLE) || stop_end);
    assign load     = pop;
    assign load_data = mem_q[rd_q];
    assign busy     = (state_q != ST_IDLE) || !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + PTR_W'(push);
            rd_q  <= rd_q + PTR_W'(pop);
            cnt_q <= cnt_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= tx_data;
        end
    end
`else
    assign tx_ready  = !rst && ((state_q == ST_IDLE) || stop_end);
    assign load      = tx_valid && tx_ready;
    assign load_data = tx_data;
    assign busy      = (state_q != ST_IDLE);
`endif

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        par_d   = par_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_IDLE: ;
            ST_START: if (tick) state_d = ST_DATA;
            ST_DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == LAST_BIT) begin
                        idx_d   = '0;
                        state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_PARITY: if (tick) state_d = ST_STOP;
            ST_STOP: begin
                if (tick) begin
                    if (idx_q == LAST_STOP) begin
                        idx_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (load) begin
            state_d = ST_START;
            shift_d = load_data;
            par_d   = parity_of(load_data);
            idx_d   = '0;
        end
    end

    always_comb begin
        tx = 1'b1;
        case (state_q)
            ST_START:  tx = 1'b0;
            ST_DATA:   tx = shift_q[0];
            ST_PARITY: tx = par_q;
            default:   tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        par_q   <= par_d;
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: several configurations side by side at 4 clocks per bit.
// Expected line levels are queued per bit when a word is sent and compared every clock.
module tb_uart_tx_param;
    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       vld    [5];
    logic [8:0] data_w [5];
    logic       tx_w   [5];
    logic       rdy_w  [5];
    logic       busy_w [5];

    int   checks   = 0;
    int   failures = 0;
    logic q_exp [$];
    logic got_bits [64];

    always #5 clk = ~clk;

    // 0: 8N1, 1: 8E1, 2: 8O1, 3: 7N2, 4: 8N1 (FIFO instance when UARTTX_FIFO_EN)
    uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .rst(rst), .tx_valid(vld[0]), .tx_data(data_w[0][7:0]),
        .tx_ready(rdy_w[0]), .tx(tx_w[0]), .busy(busy_w[0]));
    uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .rst(rst), .tx_valid(vld[1]), .tx_data(data_w[1][7:0]),
        .tx_ready(rdy_w[1]), .tx(tx_w[1]), .busy(busy_w[1]));
    uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
        .clk(clk), .rst(rst), .tx_valid(vld[2]), .tx_data(data_w[2][7:0]),
        .tx_ready(rdy_w[2]), .tx(tx_w[2]), .busy(busy_w[2]));
    uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u3 (
        .clk(clk), .rst(rst), .tx_valid(vld[3]), .tx_data(data_w[3][6:0]),
        .tx_ready(rdy_w[3]), .tx(tx_w[3]), .busy(busy_w[3]));
    uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u4 (
        .clk(clk), .rst(rst), .tx_valid(vld[4]), .tx_data(data_w[4][7:0]),
        .tx_ready(rdy_w[4]), .tx(tx_w[4]), .busy(busy_w[4]));

    // Reference frame: start, payload LSB first, parity (1 odd / 2 even), stop bits
    function automatic void push_frame(input logic [8:0] d, input int nbits, input int par, input int stops);
        logic p = 1'b0;
        q_exp.push_back(1'b0);
        for (int i = 0; i < nbits; i++) begin
            q_exp.push_back(d[i]);
            p = p ^ d[i];
        end
        if (par == 1) q_exp.push_back(~p);
        else if (par == 2) q_exp.push_back(p);
        for (int i = 0; i < stops; i++) q_exp.push_back(1'b1);
    endfunction

    // Present one word at a negedge; it is accepted on the following posedge
    task automatic start_word(input int k, input logic [8:0] d);
        @(negedge clk);
        vld[k]    = 1'b1;
        data_w[k] = d;
        @(posedge clk);
        #1;
        vld[k]    = 1'b0;
        data_w[k] = 'x;
    endtask

    // Pop the scoreboard one bit at a time, comparing tx on every clock of that bit
    task automatic drain(input int k, input string name);
        int bi = 0;
        while (q_exp.size() > 0) begin
            logic e = q_exp.pop_front();
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                if (c == CPB / 2) got_bits[bi] = tx_w[k];
                checks++;
                if (tx_w[k] !== e) begin
                    failures++;
                    $display("FAIL %s bit%0d cyc%0d: tx=%b expected %b", name, bi, c, tx_w[k], e);
                end
                if (q_exp.size() == 0 && c == CPB - 1) begin
                    checks++;
                    if (rdy_w[k] !== 1'b1) begin
                        failures++;
                        $display("FAIL %s_last_stop_ready: tx_ready=%b expected 1", name, rdy_w[k]);
                    end
                end
            end
            bi++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            vld[k]    = 1'b0;
            data_w[k] = 'x;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (tx_w[k] !== 1'b1 || busy_w[k] !== 1'b0 || rdy_w[k] !== 1'b0) begin
                failures++;
                $display("FAIL reset_u%0d: tx=%b busy=%b ready=%b expected 1 0 0", k, tx_w[k], busy_w[k], rdy_w[k]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (rdy_w[k] !== 1'b1 || tx_w[k] !== 1'b1) begin
                failures++;
                $display("FAIL idle_ready_u%0d: ready=%b tx=%b expected 1 1", k, rdy_w[k], tx_w[k]);
            end
        end
    endtask

    task automatic test_8n1;
        push_frame(9'h055, 8, 0, 1);
        start_word(0, 9'h055);
        drain(0, "8n1_55");
        @(negedge clk);
        checks++;
        if (busy_w[0] !== 1'b0 || tx_w[0] !== 1'b1) begin
            failures++;
            $display("FAIL 8n1_idle_after: busy=%b tx=%b expected 0 1", busy_w[0], tx_w[0]);
        end
    endtask

    task automatic test_parity;
        push_frame(9'h007, 8, 2, 1);
        start_word(1, 9'h007);
        drain(1, "even_07");
        checks++;
        if (got_bits[9] !== 1'b1) begin
            failures++;
            $display("FAIL even_parity_bit: got %b expected 1", got_bits[9]);
        end
        push_frame(9'h007, 8, 1, 1);
        start_word(2, 9'h007);
        drain(2, "odd_07");
        checks++;
        if (got_bits[9] !== 1'b0) begin
            failures++;
            $display("FAIL odd_parity_bit: got %b expected 0", got_bits[9]);
        end
        push_frame(9'h0B4, 8, 2, 1);
        start_word(1, 9'h0B4);
        drain(1, "even_b4");
        checks++;
        if (got_bits[9] !== 1'b0) begin
            failures++;
            $display("FAIL even_parity_b4: got %b expected 0", got_bits[9]);
        end
    endtask

    task automatic test_back_to_back;
        int waited = 0;
        bit second = 0;
        push_frame(9'h0A3, 8, 0, 1);
        push_frame(9'h05C, 8, 0, 1);
        @(negedge clk);
        vld[0]    = 1'b1;
        data_w[0] = 9'h0A3;
        @(posedge clk);
        #1;
        data_w[0] = 9'h05C;
        fork
            drain(0, "b2b");
            begin
                while (!second && waited < 100) begin
                    @(negedge clk);
                    waited++;
                    if (rdy_w[0] === 1'b1) begin
                        @(posedge clk);
                        #1;
                        vld[0]    = 1'b0;
                        data_w[0] = 'x;
                        second    = 1;
                    end
                end
            end
        join
        checks++;
        if (!second || waited != 40) begin
            failures++;
            $display("FAIL b2b_second_accept: accepted=%0d at cycle %0d expected 1 at 40", second, waited);
        end
    endtask

    task automatic test_7n2;
        push_frame(9'h07F, 7, 0, 2);
        start_word(3, 9'h07F);
        drain(3, "7n2_7f");
        @(negedge clk);
        checks++;
        if (busy_w[3] !== 1'b0) begin
            failures++;
            $display("FAIL 7n2_idle_after: busy=%b expected 0", busy_w[3]);
        end
    endtask

    task automatic test_reset_midframe;
        start_word(0, 9'h0FF);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            checks++;
            if (tx_w[0] !== (c > 4)) begin
                failures++;
                $display("FAIL midframe_cyc%0d: tx=%b expected %b", c, tx_w[0], (c > 4));
            end
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || rdy_w[0] !== 1'b0) begin
            failures++;
            $display("FAIL midframe_reset: tx=%b busy=%b ready=%b expected 1 0 0", tx_w[0], busy_w[0], rdy_w[0]);
        end
        rst = 1'b0;
        push_frame(9'h03C, 8, 0, 1);
        start_word(0, 9'h03C);
        drain(0, "after_reset_3c");
    endtask

`ifdef UARTTX_FIFO_EN
    task automatic test_fifo;
        int accepted = 0;
        int guard = 0;
        for (int w = 1; w <= 5; w++) push_frame(9'(w), 8, 0, 1);
        @(negedge clk);
        vld[4]    = 1'b1;
        data_w[4] = 9'h001;
        @(posedge clk);
        #1;
        accepted  = 1;
        data_w[4] = 9'h002;
        fork
            begin
                while (accepted < 5 && guard < 50) begin
                    @(negedge clk);
                    guard++;
                    if (rdy_w[4] === 1'b1) begin
                        @(posedge clk);
                        #1;
                        accepted++;
                        data_w[4] = 9'(accepted + 1);
                    end
                end
                vld[4]    = 1'b0;
                data_w[4] = 'x;
                @(negedge clk);
                checks++;
                if (accepted != 5 || rdy_w[4] !== 1'b0) begin
                    failures++;
                    $display("FAIL fifo_full: accepted=%0d ready=%b expected 5 0", accepted, rdy_w[4]);
                end
            end
            begin
                @(negedge clk);
                checks++;
                if (tx_w[4] !== 1'b1) begin
                    failures++;
                    $display("FAIL fifo_latency: tx=%b one cycle after push, expected 1", tx_w[4]);
                end
                drain(4, "fifo_seq");
            end
        join
        @(negedge clk);
        checks++;
        if (busy_w[4] !== 1'b0) begin
            failures++;
            $display("FAIL fifo_idle_after: busy=%b expected 0", busy_w[4]);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_back_to_back();
        test_7n2();
        test_reset_midframe();
`ifdef UARTTX_FIFO_EN
        test_fifo();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
